// File: rtl/conv3x3_window_sched_if.sv
// Handshake and tap bundle between the frame sequencer and its neighbours:
// the pixel source, the 3x3 conv datapath and the frame controller.
interface conv3x3_window_sched_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [DATA_WIDTH-1:0] pix_in;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [DATA_WIDTH-1:0] win0;
    logic [DATA_WIDTH-1:0] win1;
    logic [DATA_WIDTH-1:0] win2;
    logic [DATA_WIDTH-1:0] win3;
    logic [DATA_WIDTH-1:0] win4;
    logic [DATA_WIDTH-1:0] win5;
    logic [DATA_WIDTH-1:0] win6;
    logic [DATA_WIDTH-1:0] win7;
    logic [DATA_WIDTH-1:0] win8;
    logic                  win_valid;
    logic                  res_valid;
    logic                  busy;
    logic                  frame_done;

    // Environment side: drives pixels, start and conv results.
    modport master (
        output start, pix_in, pix_valid, res_valid,
        input  pix_ready, win0, win1, win2, win3, win4, win5, win6, win7, win8,
        input  win_valid, busy, frame_done
    );

    // Sequencer side.
    modport slave (
        input  start, pix_in, pix_valid, res_valid,
        output pix_ready, win0, win1, win2, win3, win4, win5, win6, win7, win8,
        output win_valid, busy, frame_done
    );
endinterface

// File: rtl/conv3x3_window_sched.sv
// Frame sequencer for the 3x3 convolution pipeline: buffers two image lines,
// forms a sliding 3x3 window over a row-major pixel stream, issues one window
// per fully-interior position and counts returned results to close the frame.
module conv3x3_window_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int CONV_LAT   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    conv3x3_window_sched_if.slave   bus
);

    localparam int CW        = $clog2(IMG_W);
    localparam int RW        = $clog2(IMG_H);
    localparam int RES_TOTAL = (IMG_W - 2) * (IMG_H - 2);
    localparam int RES_W     = $clog2(RES_TOTAL + 1);

    localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0]    COL_TWO  = CW'(2);
    localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0]    ROW_TWO  = RW'(2);
    localparam logic [RES_W-1:0] RES_MAX  = RES_W'(RES_TOTAL);

    // Reject geometries the window logic cannot handle.
    if (IMG_W < 3 || IMG_W > 1024 || IMG_H < 3 || IMG_H > 1024 || CONV_LAT < 1) begin : g_param_check
        $error("conv3x3_window_sched: IMG_W/IMG_H must be 3..1024 and CONV_LAT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [RES_W-1:0]        res_cnt_q, res_cnt_d;
    logic [DATA_WIDTH-1:0]   win_q [0:8];
    logic [DATA_WIDTH-1:0]   win_d [0:8];
    logic                    win_valid_q, win_valid_d;

    // Line buffers: linebuf0 holds the previous row, linebuf1 the row above it.
    // Not reset; stale contents never reach a valid window because win_valid
    // needs row >= 2.
    logic [DATA_WIDTH-1:0]   linebuf0_q [0:IMG_W-1];
    logic [DATA_WIDTH-1:0]   linebuf1_q [0:IMG_W-1];

    logic                    accept;
    logic                    last_pix;
    logic                    res_take;
    logic                    frame_start;
    logic [DATA_WIDTH-1:0]   lb0_rd;
    logic [DATA_WIDTH-1:0]   lb1_rd;
    logic                    pix_ready_o;
    logic                    busy_o;
    logic                    frame_done_o;

    // Handshake qualifiers shared by the FSM, counters and window.
    always_comb begin
        frame_start = (state_q == S_IDLE) && bus.start;
        accept      = (state_q == S_RUN) && bus.pix_valid;
        last_pix    = (row_q == ROW_LAST) && (col_q == COL_LAST);
        // Results only count while a frame is in flight; extras saturate.
        res_take    = ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                      bus.res_valid && (res_cnt_q != RES_MAX);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; DRAIN exits on the count including this cycle's result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start)              state_d = S_RUN;
            S_RUN:   if (accept && last_pix)     state_d = S_DRAIN;
            S_DRAIN: if (res_cnt_d == RES_MAX)   state_d = S_DONE;
            S_DONE:                              state_d = S_IDLE;
            default:                             state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        pix_ready_o  = 1'b0;
        busy_o       = 1'b0;
        frame_done_o = 1'b0;
        case (state_q)
            S_IDLE:  ;
            S_RUN:   begin pix_ready_o = 1'b1; busy_o = 1'b1; end
            S_DRAIN: busy_o = 1'b1;
            S_DONE:  begin busy_o = 1'b1; frame_done_o = 1'b1; end
            default: ;
        endcase
    end

    // Column/row position of the next pixel and the returned-result count.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        res_cnt_d = res_cnt_q;
        if (frame_start) begin
            col_d     = '0;
            row_d     = '0;
            res_cnt_d = '0;
        end else begin
            if (accept) begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            if (res_take) begin
                res_cnt_d = res_cnt_q + RES_W'(1);
            end
        end
    end

    // Shift the window left on each accepted pixel and flag interior positions.
    always_comb begin
        win_d       = win_q;
        win_valid_d = 1'b0;
        lb0_rd      = linebuf0_q[col_q];
        lb1_rd      = linebuf1_q[col_q];
        if (accept) begin
            win_d[0]    = win_q[1];
            win_d[1]    = win_q[2];
            win_d[2]    = lb1_rd;
            win_d[3]    = win_q[4];
            win_d[4]    = win_q[5];
            win_d[5]    = lb0_rd;
            win_d[6]    = win_q[7];
            win_d[7]    = win_q[8];
            win_d[8]    = bus.pix_in;
            win_valid_d = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
        end
    end

    // Counter, window and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            res_cnt_q   <= '0;
            win_valid_q <= 1'b0;
            win_q       <= '{default: '0};
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            res_cnt_q   <= res_cnt_d;
            win_valid_q <= win_valid_d;
            win_q       <= win_d;
        end
    end

    // Line buffer update: push the column down one line and store the new pixel.
    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf1_q[col_q] <= linebuf0_q[col_q];
            linebuf0_q[col_q] <= bus.pix_in;
        end
    end

    assign bus.pix_ready  = pix_ready_o;
    assign bus.busy       = busy_o;
    assign bus.frame_done = frame_done_o;
    assign bus.win_valid  = win_valid_q;
    assign bus.win0       = win_q[0];
    assign bus.win1       = win_q[1];
    assign bus.win2       = win_q[2];
    assign bus.win3       = win_q[3];
    assign bus.win4       = win_q[4];
    assign bus.win5       = win_q[5];
    assign bus.win6       = win_q[6];
    assign bus.win7       = win_q[7];
    assign bus.win8       = win_q[8];

endmodule

// File: doc/conv3x3_window_sched.md
Name: conv3x3_window_sched

Overview:
- Sequences one frame through the 3x3 floating-point convolution pipeline.
- Accepts a row-major pixel stream and holds two line buffers plus a 3x3 shift window.
- Issues a 9-tap window with a valid strobe for every position where the full 3x3 window lies inside the image (no padding).
- Counts pipeline results returned by the conv datapath and pulses frame_done when the last result arrives.

Parameters:
- DATA_WIDTH, 32, pixel/tap width (IEEE-754 single, treated as raw bits here)
- IMG_W, 8, image width in pixels, legal range 3..1024
- IMG_H, 8, image height in pixels, legal range 3..1024
- CONV_LAT, 5, conv datapath latency from win_valid to res_valid (informational; bench check only)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- pix_in  in  DATA_WIDTH  incoming pixel, row-major
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  block can accept a pixel this cycle
- win0..win8  out  DATA_WIDTH each  window taps, row-major; win0 = top-left, win8 = bottom-right (newest pixel)
- win_valid  out  1  taps valid; drives conv valid_in
- res_valid  in  1  conv valid_out
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when the final result is received

Behaviour:
- Reset (synchronous, active-high): state=IDLE; pix_ready=0, win_valid=0, busy=0, frame_done=0; col/row/result counters=0; win0..win8=0.
- Line buffer RAM contents are not reset; they are masked by the counters.
- rst asserted mid-frame aborts the frame. No frame_done is issued. Any res_valid after reset is ignored until the next start.
- States:
  - IDLE: start -> RUN and clear counters. pix_ready=0.
  - RUN: pix_ready=1. A pixel is accepted when pix_valid&pix_ready. Accepting pixel (row=IMG_H-1, col=IMG_W-1) -> DRAIN.
  - DRAIN: pix_ready=0. Wait until the result count reaches (IMG_W-2)*(IMG_H-2), then -> DONE.
  - DONE: frame_done=1 for exactly one cycle -> IDLE.
- Counters:
  - col increments per accepted pixel and wraps IMG_W-1 -> 0.
  - row increments on col wrap.
  - Gaps in pix_valid stall the counters; window state holds.
- Window:
  - On each accepted pixel, the three window rows shift left by one column.
  - New right column = {linebuf1[col], linebuf0[col], pix_in}.
  - linebuf1[col] <= linebuf0[col]; linebuf0[col] <= pix_in.
- win_valid:
  - Asserted exactly one cycle after accepting a pixel with row>=2 and col>=2; taps are registered with it.
  - Deasserted in all other cycles.
  - Never asserted twice for one position.
- Windows issued per frame = (IMG_W-2)*(IMG_H-2).
- Result counter:
  - Increments on res_valid in RUN or DRAIN, saturating at the expected count.
  - Extra res_valid is ignored.
  - res_valid in IDLE or DONE is ignored.
- Simultaneous events:
  - Final res_valid in the same cycle the last pixel is accepted is counted. The DRAIN exit condition uses the updated count.
  - start during RUN, DRAIN or DONE is ignored.
- busy=1 in RUN, DRAIN and DONE.

Test Plan:
- IMG_W=4, IMG_H=4, start, pixels 0..15 back-to-back:
  - 4 win_valid pulses.
  - First occurs the cycle after pixel 10 is accepted, with taps 0,1,2,4,5,6,8,9,10.
  - Last has taps 5,6,7,9,10,11,13,14,15.
- Same stream, pix_valid toggled 1/0 every cycle:
  - Identical tap sets and order.
  - win_valid only one cycle after accepted pixels.
  - pix_ready=0 after pixel 15.
- Conv model (CONV_LAT=5) returning res_valid:
  - frame_done pulses exactly one cycle after the 4th res_valid.
  - busy falls the same cycle frame_done falls.
  - State returns to IDLE.
- rst asserted after pixel 9 of a 4x4 frame:
  - Next cycle pix_ready=0, busy=0, win_valid=0.
  - New start with pixels 0..15 reproduces scenario 1 exactly.
- start pulsed during RUN and res_valid pulsed in IDLE:
  - No effect on counters, state or frame_done timing.
- IMG_W=3, IMG_H=3, pixels 1..9:
  - Single win_valid with taps 1..9 in order.
  - frame_done after one res_valid.
